mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes the opcode and sequences
//  fetch/decode/execute/memory/writeback, driving every datapath enable and mux select.
//  Produces the 2-bit ALUOp consumed by the ALU control decoder:
//  00 = add, 01 = subtract (branch compare), 10 = decode from funct field.
//  Also stalls on memory wait states and counts retired instructions.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_J      6'b000010  jump
//  OP_ADDI   6'b001000  add immediate
//  CNT_W     32         width of the retired-instruction counter
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  reset         in   1      synchronous, active-high
//  op            in   6      opcode from instruction register (IR[31:26])
//  mem_ready     in   1      memory access completes this cycle
//  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//  pc_write, pc_write_cond
//                out  1 each datapath controls
//  alu_src_b     out  2      00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op        out  2      00 = add, 01 = sub, 10 = funct
//  pc_source     out  2      00 = ALU result, 01 = ALUOut, 10 = jump target
//  state         out  4      current state code (debug)
//  illegal_op    out  1      one-cycle pulse, unsupported opcode
//  instr_count   out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset: at a rising edge with reset=1, state <= RST (0), instr_count <= 0,
//   regardless of current state (aborts mid-instruction, including memory waits).
//   All outputs are 0 in RST. RST -> FETCH unconditionally on the next edge.
//  States: 0 RST, 1 FETCH, 2 DECODE, 3 MEM_ADDR, 4 MEM_RD, 5 MEM_WB, 6 MEM_WR,
//   7 R_EX, 8 R_WB, 9 BRANCH, 10 JUMP, 11 ADDI_EX, 12 ADDI_WB.
//   Codes 13-15 are unreachable; if entered, go to FETCH.
//  Outputs are Moore (decoded from state) except ir_write and pc_write in FETCH.
//   Any output not listed for a state is 0.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00,
//   ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; else -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op:
//   LW/SW -> MEM_ADDR; RTYPE -> R_EX; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDI_EX;
//   other -> FETCH with illegal_op=1 for that DECODE cycle. No count increment.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_RD, SW -> MEM_WR.
//   op is re-sampled here; it is stable because the IR is only written in FETCH.
//  MEM_RD: mem_read=1, iord=1. Hold while !mem_ready; else -> MEM_WB.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEM_WR: mem_write=1, iord=1. Hold while !mem_ready; else -> FETCH.
//  R_EX: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
//  R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  JUMP: pc_write=1, pc_source=10 -> FETCH.
//  ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
//  ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
//  Latency in cycles, excluding waits: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
//  instr_count: +1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH,
//   JUMP or ADDI_WB. It wraps modulo 2^CNT_W. Reset has priority over increment.
//  mem_write and mem_read are never both 1. reg_write and mem_write are never both 1.
// TESTING
//  reset 1 cycle; mem_ready=1 -> state RST, then FETCH, then DECODE; all outputs 0 in RST.
//  op=6'b100011, mem_ready=1 -> states 1,2,3,4,5,1; reg_write=1 only in 5; instr_count=1.
//  op=6'b101011, mem_ready=0 for 3 cycles in MEM_WR -> mem_write held 4 cycles,
//   then FETCH; reg_write never 1.
//  op=6'b000000 -> alu_op=10 in R_EX, reg_dst=1 in R_WB. op=6'b000100 -> alu_op=01,
//   pc_write_cond=1 for 1 cycle.
//  op=6'b111111 -> illegal_op=1 for 1 cycle in DECODE, back to FETCH, instr_count unchanged.
//  reset asserted in MEM_RD while waiting -> RST on next edge; CNT_W=4, 16 JUMPs -> count wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multicycle MIPS datapath
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EX     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    state_t cur, nxt;
    logic   retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_RST;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state = cur;

    always_comb begin
        nxt           = S_FETCH;
        retire        = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (cur)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nxt       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (op == OP_LW || op == OP_SW) nxt = S_MEM_ADDR;
                else if (op == OP_RTYPE)        nxt = S_R_EX;
                else if (op == OP_BEQ)          nxt = S_BRANCH;
                else if (op == OP_J)            nxt = S_JUMP;
                else if (op == OP_ADDI)         nxt = S_ADDI_EX;
                else begin
                    nxt        = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // op is stable here since the IR only loads in FETCH
                if (op == OP_LW)      nxt = S_MEM_RD;
                else if (op == OP_SW) nxt = S_MEM_WR;
                else                  nxt = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                nxt      = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                nxt       = mem_ready ? S_FETCH : S_MEM_WR;
                retire    = mem_ready;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_write, pc_write_cond, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [3:0] instr_count;
    logic [16:0] ctl;

    int vectors = 0;
    int miscompares = 0;

    mips_multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctl = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, pc_write, pc_write_cond, alu_src_b, alu_op, pc_source, illegal_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        check("rw_wr_excl", 32'(reg_write & mem_write), 32'd0);
    endtask

    initial begin
        reset = 1'b1; op = 6'b100011; mem_ready = 1'b1;
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;

        // LW: 1,2,3,4,5,1
        step();
        check("lw_fetch", 32'(state), 32'd1);
        check("lw_fetch_ctl", 32'({mem_read, ir_write, pc_write, iord, alu_src_b}), 32'b111001);
        step();
        check("lw_decode", 32'(state), 32'd2);
        check("lw_decode_srcb", 32'(alu_src_b), 32'd3);
        step();
        check("lw_addr", 32'(state), 32'd3);
        check("lw_addr_ctl", 32'({alu_src_a, alu_src_b, alu_op}), 32'b11000);
        step();
        check("lw_rd", 32'(state), 32'd4);
        check("lw_rd_ctl", 32'({mem_read, iord, reg_write}), 32'b110);
        step();
        check("lw_wb", 32'(state), 32'd5);
        check("lw_wb_ctl", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
        step();
        check("lw_done", 32'(state), 32'd1);
        check("lw_count", 32'(instr_count), 32'd1);
        check("lw_fetch_rw", 32'(reg_write), 32'd0);

        // Fetch stall, then SW with three wait cycles
        op = 6'b101011; mem_ready = 1'b0;
        #1;
        check("fetch_stall_irw", 32'({ir_write, pc_write}), 32'd0);
        step();
        check("fetch_stall_state", 32'(state), 32'd1);
        mem_ready = 1'b1;
        step();
        check("sw_decode", 32'(state), 32'd2);
        step();
        check("sw_addr", 32'(state), 32'd3);
        step();
        check("sw_wr", 32'(state), 32'd6);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("sw_hold_state", 32'(state), 32'd6);
            check("sw_hold_ctl", 32'({mem_write, iord, reg_write, mem_read}), 32'b1100);
            if (i == 3) mem_ready = 1'b1;
            if (i < 3) step();
        end
        step();
        check("sw_done", 32'(state), 32'd1);
        check("sw_count", 32'(instr_count), 32'd2);

        // R-type
        op = 6'b000000;
        step();
        step();
        check("r_ex", 32'(state), 32'd7);
        check("r_ex_ctl", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10010);
        step();
        check("r_wb", 32'(state), 32'd8);
        check("r_wb_ctl", 32'({reg_dst, reg_write, mem_to_reg}), 32'b110);
        step();
        check("r_count", 32'(instr_count), 32'd3);

        // BEQ
        op = 6'b000100;
        step();
        step();
        check("beq_state", 32'(state), 32'd9);
        check("beq_ctl", 32'({alu_src_a, alu_src_b, alu_op, pc_write_cond, pc_source}), 32'b10001101);
        step();
        check("beq_done", 32'(state), 32'd1);
        check("beq_pwc_off", 32'(pc_write_cond), 32'd0);
        check("beq_count", 32'(instr_count), 32'd4);

        // ADDI
        op = 6'b001000;
        step();
        step();
        check("addi_ex", 32'(state), 32'd11);
        check("addi_ex_ctl", 32'({alu_src_a, alu_src_b, alu_op}), 32'b11000);
        step();
        check("addi_wb", 32'(state), 32'd12);
        check("addi_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'b100);
        step();
        check("addi_count", 32'(instr_count), 32'd5);

        // Illegal opcode
        op = 6'b111111;
        step();
        check("ill_decode", 32'(state), 32'd2);
        check("ill_pulse", 32'(illegal_op), 32'd1);
        step();
        check("ill_back", 32'(state), 32'd1);
        check("ill_pulse_off", 32'(illegal_op), 32'd0);
        check("ill_count", 32'(instr_count), 32'd5);

        // Reset while waiting in MEM_RD
        op = 6'b100011;
        step();
        step();
        mem_ready = 1'b0;
        step();
        check("rdwait_state", 32'(state), 32'd4);
        step();
        check("rdwait_hold", 32'(state), 32'd4);
        reset = 1'b1;
        step();
        check("abort_state", 32'(state), 32'd0);
        check("abort_count", 32'(instr_count), 32'd0);
        check("abort_ctl", 32'(ctl), 32'd0);
        reset = 1'b0; mem_ready = 1'b1;
        step();
        check("abort_fetch", 32'(state), 32'd1);

        // 16 jumps wrap a 4-bit counter
        op = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            step();
            step();
            check("j_state", 32'(state), 32'd10);
            check("j_ctl", 32'({pc_write, pc_source, ir_write}), 32'b1100);
            step();
            check("j_count", 32'(instr_count), 32'((i + 1) % 16));
        end
        check("j_wrap", 32'(instr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
